dw_div_recon_seq: RTL and testbench

//  Sequential inverse of the team's combinational divider: rebuilds dividend = quotient*divisor + remainder.

---
 rtl/dw_div_recon_seq_if.sv | 26 ++
 rtl/dw_div_recon_seq.sv | 140 ++++++++++++++
 tb/tb_dw_div_recon_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dw_div_recon_seq_if.sv
// Handshake and operand/result bundle for dw_div_recon_seq.
interface dw_div_recon_seq_if #(
  parameter int a_width = 32,
  parameter int b_width = 16
);
  logic               start;
  logic [a_width-1:0] quotient;
  logic [b_width-1:0] divisor;
  logic [b_width-1:0] remainder;
  logic               busy;
  logic               done;
  logic [a_width-1:0] dividend;
  logic               overflow;
  logic               divide_by_0;
  logic               rem_err;

  modport master (
    output start, quotient, divisor, remainder,
    input  busy, done, dividend, overflow, divide_by_0, rem_err
  );

  modport slave (
    input  start, quotient, divisor, remainder,
    output busy, done, dividend, overflow, divide_by_0, rem_err
  );
endinterface

// File: rtl/dw_div_recon_seq.sv
// Sequential dividend reconstruction q*b+r via radix-2 shift-add over b_width cycles.
// Optional remainder range check enabled by macro DW_DIV_RECON_REMCHK_EN.
module dw_div_recon_seq #(
  parameter int a_width = 32,
  parameter int b_width = 16,
  parameter int tc_mode = 0
) (
  input logic               clk,
  input logic               rst_n,
  dw_div_recon_seq_if.slave bus
);
  localparam int W  = a_width + b_width;
  localparam int CW = $clog2(b_width) + 1;

  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
  state_t state, state_next;

  logic [W-1:0]       acc, mcand;
  logic [b_width-1:0] b_sh, r_reg;
  logic [CW-1:0]      cnt;
  logic               sign, dz;
  logic               busy_q, done_q, ovf_q, dz_q, rem_q;
  logic [a_width-1:0] dividend_q;

  logic [a_width-1:0] q_mag;
  logic [b_width-1:0] b_mag_in;
  logic               sign_in;
  logic [W:0]         prod_ext, signed_prod, r_ext, full;
  logic               ovf, rerr;

  always_comb begin
    q_mag    = bus.quotient;
    b_mag_in = bus.divisor;
    sign_in  = 1'b0;
    if (tc_mode != 0) begin
      if (bus.quotient[a_width-1]) q_mag    = '0 - bus.quotient;
      if (bus.divisor[b_width-1])  b_mag_in = '0 - bus.divisor;
      sign_in = bus.quotient[a_width-1] ^ bus.divisor[b_width-1];
    end
  end

  // Final sum is one bit wider than the product so the exact value is never lost.
  always_comb begin
    prod_ext    = {1'b0, acc};
    signed_prod = sign ? ('0 - prod_ext) : prod_ext;
    r_ext       = {{(W+1-b_width){(tc_mode != 0) && r_reg[b_width-1]}}, r_reg};
    full        = signed_prod + r_ext;
    if (tc_mode != 0)
      ovf = !((&full[W:a_width-1]) || !(|full[W:a_width-1]));
    else
      ovf = |full[W:a_width];
  end

`ifdef DW_DIV_RECON_REMCHK_EN
  logic [b_width-1:0] b_mag_r, r_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       b_mag_r <= '0;
    else if (state == IDLE && bus.start) b_mag_r <= b_mag_in;
  end

  always_comb begin
    r_mag = r_reg;
    if ((tc_mode != 0) && r_reg[b_width-1]) r_mag = '0 - r_reg;
    rerr = !dz && ((r_mag >= b_mag_r) ||
           ((tc_mode != 0) && (r_reg != '0) && (r_reg[b_width-1] != full[W])));
  end
`else
  always_comb rerr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = MUL;
      MUL:     if (cnt == CW'(b_width - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mcand      <= '0;
      b_sh       <= '0;
      r_reg      <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      dz         <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      rem_q      <= 1'b0;
      dividend_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          acc    <= '0;
          mcand  <= {{b_width{1'b0}}, q_mag};
          b_sh   <= b_mag_in;
          r_reg  <= bus.remainder;
          sign   <= sign_in;
          dz     <= (bus.divisor == '0);
          cnt    <= '0;
          busy_q <= 1'b1;
        end
        MUL: begin
          if (b_sh[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          dividend_q <= full[a_width-1:0];
          ovf_q      <= ovf;
          dz_q       <= dz;
          rem_q      <= rerr;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.dividend    = dividend_q;
  assign bus.overflow    = ovf_q;
  assign bus.divide_by_0 = dz_q;
  assign bus.rem_err     = rem_q;
endmodule

// File: tb/tb_dw_div_recon_seq.sv
// Scoreboard bench: unsigned and two's-complement instances driven with directed vectors.
module tb_dw_div_recon_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dw_div_recon_seq_if #(.a_width(32), .b_width(16)) bus_u ();
  dw_div_recon_seq_if #(.a_width(32), .b_width(16)) bus_s ();

  dw_div_recon_seq #(.a_width(32), .b_width(16), .tc_mode(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bus_u));
  dw_div_recon_seq #(.a_width(32), .b_width(16), .tc_mode(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  typedef struct packed {
    logic [31:0] dividend;
    logic        ovf;
    logic        dz;
    logic        rem;
  } exp_t;

  exp_t qu[$];
  exp_t qs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic compare(input string who, input exp_t e, input logic [31:0] d,
                         input logic o, input logic z, input logic r);
    check({who, " result"}, {29'd0, d, o, z, r}, {29'd0, e});
  endtask

  always @(negedge clk) begin
    if (bus_u.done) begin
      if (qu.size() == 0) check("u unexpected done", 64'd1, 64'd0);
      else compare("u", qu.pop_front(), bus_u.dividend, bus_u.overflow,
                   bus_u.divide_by_0, bus_u.rem_err);
    end
    if (bus_s.done) begin
      if (qs.size() == 0) check("s unexpected done", 64'd1, 64'd0);
      else compare("s", qs.pop_front(), bus_s.dividend, bus_s.overflow,
                   bus_s.divide_by_0, bus_s.rem_err);
    end
  end

  task automatic drive(input bit s, input logic st, input logic [31:0] q,
                       input logic [15:0] b, input logic [15:0] r);
    if (s) begin
      bus_s.start = st; bus_s.quotient = q; bus_s.divisor = b; bus_s.remainder = r;
    end else begin
      bus_u.start = st; bus_u.quotient = q; bus_u.divisor = b; bus_u.remainder = r;
    end
  endtask

  function automatic logic rem_exp(input logic er);
`ifdef DW_DIV_RECON_REMCHK_EN
    return er;
`else
    return 1'b0 & er;
`endif
  endfunction

  // Launch one operation, push its expectation, and verify latency and busy.
  task automatic run(input bit s, input logic [31:0] q, input logic [15:0] b,
                     input logic [15:0] r, input logic [31:0] ed, input logic eo,
                     input logic ez, input logic er);
    exp_t e;
    int n;
    bit busy_ok;
    logic dn, bz;
    e = '{dividend: ed, ovf: eo, dz: ez, rem: rem_exp(er)};
    @(negedge clk);
    drive(s, 1'b1, q, b, r);
    if (s) qs.push_back(e); else qu.push_back(e);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 32'hDEAD_BEEF, 16'hA5A5, 16'h5A5A);
    n = 0;
    busy_ok = 1'b1;
    dn = 1'b0;
    bz = 1'b1;
    while (!dn && n < 40) begin
      if (!(s ? bus_s.busy : bus_u.busy)) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
      dn = s ? bus_s.done : bus_u.done;
      bz = s ? bus_s.busy : bus_u.busy;
    end
    check("done latency", 64'(n), 64'd17);
    check("busy while running", {63'd0, busy_ok}, 64'd1);
    check("busy low at done", {63'd0, bz}, 64'd0);
  endtask

  initial begin
    int dones[$];
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset u busy/done/dividend", {30'd0, bus_u.busy, bus_u.done, bus_u.dividend}, 64'd0);
    check("reset u flags", {61'd0, bus_u.overflow, bus_u.divide_by_0, bus_u.rem_err}, 64'd0);
    check("reset s busy/done/dividend", {30'd0, bus_s.busy, bus_s.done, bus_s.dividend}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // unsigned instance
    run(0, 32'd1000,       16'd7,      16'd6,      32'd7006,       0, 0, 0);
    run(0, 32'hFFFF_FFFF,  16'd2,      16'd1,      32'hFFFF_FFFF,  1, 0, 0);
    run(0, 32'd123,        16'd0,      16'd9,      32'd9,          0, 1, 0);
    run(0, 32'd10,         16'd5,      16'd5,      32'd55,         0, 0, 1);
    run(0, 32'd0,          16'hFFFF,   16'hFFFE,   32'h0000_FFFE,  0, 0, 0);
    run(0, 32'h0001_0000,  16'h8000,   16'd0,      32'h8000_0000,  0, 0, 0);
    run(0, 32'h0002_0000,  16'h8000,   16'd0,      32'h0000_0000,  1, 0, 0);
    // two's-complement instance
    run(1, 32'hFFFF_FFFB,  16'd3,      16'hFFFE,   32'hFFFF_FFEF,  0, 0, 0);
    run(1, 32'h8000_0000,  16'hFFFF,   16'd0,      32'h8000_0000,  1, 0, 0);
    run(1, 32'd7,          16'hFFFE,   16'd3,      32'hFFFF_FFF5,  0, 0, 1);
    run(1, 32'h8000_0000,  16'd1,      16'hFFFF,   32'h7FFF_FFFF,  1, 0, 1);
    run(1, 32'h4000_0000,  16'd2,      16'd0,      32'h8000_0000,  1, 0, 0);
    run(1, 32'hFFFF_FFFB,  16'd0,      16'hFFFF,   32'hFFFF_FFFF,  0, 1, 0);

    // start held high: launches on edges 0, 18, 36; done on 17, 35, 53
    @(negedge clk);
    drive(0, 1'b1, 32'd3, 16'd4, 16'd1);
    repeat (3) qu.push_back('{dividend: 32'd13, ovf: 1'b0, dz: 1'b0, rem: 1'b0});
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 39) bus_u.start = 1'b0;
      if (bus_u.done) dones.push_back(i);
    end
    check("b2b done count", 64'(dones.size()), 64'd3);
    if (dones.size() == 3) begin
      check("b2b done 0", 64'(dones[0]), 64'd17);
      check("b2b done 1", 64'(dones[1]), 64'd35);
      check("b2b done 2", 64'(dones[2]), 64'd53);
    end

    // reset mid-operation: nothing queued, so any later done is flagged
    @(negedge clk);
    drive(0, 1'b1, 32'd1000, 16'd7, 16'd6);
    @(posedge clk);
    #1;
    bus_u.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset mid-op busy/done/dividend", {30'd0, bus_u.busy, bus_u.done, bus_u.dividend}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    run(0, 32'd1000, 16'd7, 16'd6, 32'd7006, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("u queue drained", 64'(qu.size()), 64'd0);
    check("s queue drained", 64'(qs.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
